// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Redirect outputs are combinational; everything prefixed o_ex_ is registered.
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        i_flush,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_id_rs1_data,
    input  logic [31:0] i_id_rs2_data,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic [4:0]  i_id_reg_dest,
    input  logic [31:0] i_id_imm,
    input  logic [2:0]  i_id_funct3,
    input  logic [6:0]  i_id_funct7,
    input  logic [11:0] i_id_ctrl,
    input  logic        i_wb_reg_wr,
    input  logic [4:0]  i_wb_reg_dest,
    input  logic [31:0] i_wb_data,
    output logic        o_ex_mem_to_reg,
    output logic        o_ex_rw_sel,
    output logic        o_ex_reg_wr,
    output logic        o_ex_mem_rd,
    output logic        o_ex_mem_wr,
    output logic [31:0] o_ex_pc_plus_4,
    output logic [31:0] o_ex_alu_result,
    output logic [31:0] o_ex_reg_read_data2,
    output logic [4:0]  o_ex_reg_dest,
    output logic [2:0]  o_ex_funct3,
    output logic [6:0]  o_ex_funct7,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_target
);

    // {rw_sel, mem_to_reg, mem_wr, mem_rd, reg_wr}
    logic [4:0]  ctrl_q, ctrl_d;
    logic [31:0] pc_plus_4_q, pc_plus_4_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] rd2_q, rd2_d;
    logic [4:0]  reg_dest_q, reg_dest_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;

    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_out, sra_res, pc_plus_4;
    logic [4:0]  shamt;
    logic [1:0]  alu_mode;
    logic        alt, cond, is_jump;

    // Loads in EX/MEM have no data yet, so only ALU producers forward from there.
    always_comb begin
        rs1_fwd = i_id_rs1_data;
        if (i_id_rs1 != 5'd0 && ctrl_q[0] && !ctrl_q[3] && reg_dest_q == i_id_rs1) begin
            rs1_fwd = alu_result_q;
        end else if (i_id_rs1 != 5'd0 && i_wb_reg_wr && i_wb_reg_dest == i_id_rs1) begin
            rs1_fwd = i_wb_data;
        end
        rs2_fwd = i_id_rs2_data;
        if (i_id_rs2 != 5'd0 && ctrl_q[0] && !ctrl_q[3] && reg_dest_q == i_id_rs2) begin
            rs2_fwd = alu_result_q;
        end else if (i_id_rs2 != 5'd0 && i_wb_reg_wr && i_wb_reg_dest == i_id_rs2) begin
            rs2_fwd = i_wb_data;
        end
    end

    assign op_a      = i_id_ctrl[6] ? i_id_pc : rs1_fwd;
    assign op_b      = i_id_ctrl[5] ? i_id_imm : rs2_fwd;
    assign shamt     = op_b[4:0];
    assign alu_mode  = i_id_ctrl[11:10];
    assign sra_res   = 32'($signed(op_a) >>> shamt);
    assign pc_plus_4 = i_id_pc + 32'd4;
    assign is_jump   = i_id_ctrl[8] | i_id_ctrl[9];

    always_comb begin
        alu_out = '0;
        // funct7[5] only means SUB in R-type; in I-type it only marks SRAI.
        alt = i_id_funct7[5] & ((alu_mode == 2'b01) | (i_id_funct3 == 3'b101));
        unique case (alu_mode)
            2'b00: alu_out = op_a + op_b;
            2'b11: alu_out = op_b;
            default: begin
                case (i_id_funct3)
                    3'b000: alu_out = alt ? op_a - op_b : op_a + op_b;
                    3'b001: alu_out = op_a << shamt;
                    3'b010: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
                    3'b011: alu_out = {31'd0, op_a < op_b};
                    3'b100: alu_out = op_a ^ op_b;
                    3'b101: alu_out = alt ? sra_res : op_a >> shamt;
                    3'b110: alu_out = op_a | op_b;
                    default: alu_out = op_a & op_b;
                endcase
            end
        endcase
    end

    always_comb begin
        case (i_id_funct3)
            3'b000:  cond = rs1_fwd == rs2_fwd;
            3'b001:  cond = rs1_fwd != rs2_fwd;
            3'b100:  cond = $signed(rs1_fwd) < $signed(rs2_fwd);
            3'b101:  cond = $signed(rs1_fwd) >= $signed(rs2_fwd);
            3'b110:  cond = rs1_fwd < rs2_fwd;
            3'b111:  cond = rs1_fwd >= rs2_fwd;
            default: cond = 1'b0;
        endcase
    end

    assign o_branch_taken  = (i_id_ctrl[7] & cond) | is_jump;
    assign o_branch_target = i_id_ctrl[9] ? ((rs1_fwd + i_id_imm) & ~32'd1) : i_id_pc + i_id_imm;

    always_comb begin
        ctrl_d       = ctrl_q;
        pc_plus_4_d  = pc_plus_4_q;
        alu_result_d = alu_result_q;
        rd2_d        = rd2_q;
        reg_dest_d   = reg_dest_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        if (clk_en) begin
            if (i_flush) begin
                ctrl_d       = '0;
                pc_plus_4_d  = '0;
                alu_result_d = '0;
                rd2_d        = '0;
                reg_dest_d   = '0;
                funct3_d     = '0;
                funct7_d     = '0;
            end else begin
                ctrl_d       = i_id_ctrl[4:0];
                pc_plus_4_d  = pc_plus_4;
                alu_result_d = is_jump ? pc_plus_4 : alu_out;
                rd2_d        = rs2_fwd;
                reg_dest_d   = i_id_reg_dest;
                funct3_d     = i_id_funct3;
                funct7_d     = i_id_funct7;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q       <= '0;
            pc_plus_4_q  <= '0;
            alu_result_q <= '0;
            rd2_q        <= '0;
            reg_dest_q   <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc_plus_4_q  <= pc_plus_4_d;
            alu_result_q <= alu_result_d;
            rd2_q        <= rd2_d;
            reg_dest_q   <= reg_dest_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
        end
    end

    assign o_ex_reg_wr         = ctrl_q[0];
    assign o_ex_mem_rd         = ctrl_q[1];
    assign o_ex_mem_wr         = ctrl_q[2];
    assign o_ex_mem_to_reg     = ctrl_q[3];
    assign o_ex_rw_sel         = ctrl_q[4];
    assign o_ex_pc_plus_4      = pc_plus_4_q;
    assign o_ex_alu_result     = alu_result_q;
    assign o_ex_reg_read_data2 = rd2_q;
    assign o_ex_reg_dest       = reg_dest_q;
    assign o_ex_funct3         = funct3_q;
    assign o_ex_funct7         = funct7_q;

endmodule
